// File: rtl/key_conditioner.sv
// ============================================================================
// key_conditioner: synchronise and debounce one active-low pushbutton;
// emits a clean level, press/release/hold pulses and a press-toggled level.
// Revision: 1.0
// ============================================================================
`default_nettype none

module key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 10000,
  parameter int unsigned HOLD_CYCLES     = 10000000,
  parameter int unsigned CNT_W           = 24,
  parameter bit          TOGGLE_INIT     = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic hold_pulse,
  output logic toggle
);

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    PRESS_DEB = 2'd1,
    PRESSED   = 2'd2,
    REL_DEB   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_deb_last  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_zero      = '0;

  logic             r_s1;
  logic             r_s2;
  state_t           r_state;
  logic [CNT_W-1:0] r_deb_cnt;
  logic [CNT_W-1:0] r_hold_cnt;
  logic             r_hold_done;
  logic             r_pressed;
  logic             r_press_pulse;
  logic             r_release_pulse;
  logic             r_hold_pulse;
  logic             r_toggle;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_deb_cnt_nxt;
  logic [CNT_W-1:0] w_hold_cnt_nxt;
  logic             w_hold_done_nxt;
  logic             w_pressed_nxt;
  logic             w_press_pulse_nxt;
  logic             w_release_pulse_nxt;
  logic             w_hold_pulse_nxt;
  logic             w_toggle_nxt;

  // Two-flop synchroniser; the FSM below only ever looks at r_s2.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= key_n;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state         <= RELEASED;
      r_deb_cnt       <= c_zero;
      r_hold_cnt      <= c_zero;
      r_hold_done     <= 1'b0;
      r_pressed       <= 1'b0;
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_hold_pulse    <= 1'b0;
      r_toggle        <= TOGGLE_INIT;
    end else begin
      r_state         <= w_state_nxt;
      r_deb_cnt       <= w_deb_cnt_nxt;
      r_hold_cnt      <= w_hold_cnt_nxt;
      r_hold_done     <= w_hold_done_nxt;
      r_pressed       <= w_pressed_nxt;
      r_press_pulse   <= w_press_pulse_nxt;
      r_release_pulse <= w_release_pulse_nxt;
      r_hold_pulse    <= w_hold_pulse_nxt;
      r_toggle        <= w_toggle_nxt;
    end
  end

  always_comb begin
    w_state_nxt         = r_state;
    w_deb_cnt_nxt       = r_deb_cnt;
    w_hold_cnt_nxt      = r_hold_cnt;
    w_hold_done_nxt     = r_hold_done;
    w_pressed_nxt       = r_pressed;
    w_press_pulse_nxt   = 1'b0;
    w_release_pulse_nxt = 1'b0;
    w_hold_pulse_nxt    = 1'b0;
    w_toggle_nxt        = r_toggle;

    case (r_state)
      RELEASED: begin
        if (!r_s2) begin
          w_state_nxt   = PRESS_DEB;
          w_deb_cnt_nxt = c_zero;
        end
      end

      PRESS_DEB: begin
        if (r_s2) begin
          w_state_nxt   = RELEASED;
          w_deb_cnt_nxt = c_zero;
        end else if (r_deb_cnt == c_deb_last) begin
          w_state_nxt       = PRESSED;
          w_pressed_nxt     = 1'b1;
          w_press_pulse_nxt = 1'b1;
          w_toggle_nxt      = ~r_toggle;
          w_hold_cnt_nxt    = c_zero;
          w_hold_done_nxt   = 1'b0;
        end else begin
          w_deb_cnt_nxt = r_deb_cnt + c_one;
        end
      end

      // A release edge wins over a terminal hold count.
      PRESSED: begin
        if (r_s2) begin
          w_state_nxt   = REL_DEB;
          w_deb_cnt_nxt = c_zero;
        end else if (!r_hold_done) begin
          if (r_hold_cnt == c_hold_last) begin
            w_hold_pulse_nxt = 1'b1;
            w_hold_done_nxt  = 1'b1;
          end else begin
            w_hold_cnt_nxt = r_hold_cnt + c_one;
          end
        end
      end

      // Hold progress survives a rejected release bounce.
      REL_DEB: begin
        if (!r_s2) begin
          w_state_nxt = PRESSED;
        end else if (r_deb_cnt == c_deb_last) begin
          w_state_nxt         = RELEASED;
          w_pressed_nxt       = 1'b0;
          w_release_pulse_nxt = 1'b1;
        end else begin
          w_deb_cnt_nxt = r_deb_cnt + c_one;
        end
      end

      default: begin
        w_state_nxt = RELEASED;
      end
    endcase
  end

  assign pressed       = r_pressed;
  assign press_pulse   = r_press_pulse;
  assign release_pulse = r_release_pulse;
  assign hold_pulse    = r_hold_pulse;
  assign toggle        = r_toggle;

endmodule

`default_nettype wire
